// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes (common with the control unit) and
// the fetch-unit state encoding.
package cpu_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } fetch_state_e;

    // Branch immediate in bytes: sign-extended word offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface ifu_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection; only inst[25:0] is needed for the branch and
// jump targets.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] inst_i,
    input  logic [31:0] ra_data_i,
    input  logic [1:0]  pcsource_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    logic [31:0] pc4;

    assign pc4 = pc_i + 32'd4;

    always_comb begin
        npc_o      = pc4;
        misalign_o = 1'b0;
        unique case (pcsource_i)
            PCSRC_SEQ: npc_o = pc4;
            PCSRC_BR:  npc_o = pc4 + br_offset(inst_i[15:0]);
            PCSRC_JR: begin
                npc_o      = {ra_data_i[31:2], 2'b00};
                misalign_o = (ra_data_i[1:0] != 2'b00);
            end
            PCSRC_J:   npc_o = {pc4[31:28], inst_i, 2'b00};
            default:   npc_o = pc4;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack bus, holds the
// instruction for decode and advances the PC when the instruction commits.
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               clrn,
    ifu_fetch_if.master        imem,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        ra_data,
    input  logic               commit,
    output logic [31:0]        inst,
    output logic [31:0]        pc,
    output logic [31:0]        pc4,
    output logic               inst_valid,
    output logic               misalign_err,
    output logic               fetch_err
);

    localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         valid_q, valid_d;
    logic         mis_q, mis_d;
    logic         ferr_q, ferr_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [31:0]  npc;
    logic         npc_misalign;

    npc_calc u_npc_calc (
        .pc_i       (pc_q),
        .inst_i     (inst_q[25:0]),
        .ra_data_i  (ra_data),
        .pcsource_i (pcsource),
        .npc_o      (npc),
        .misalign_o (npc_misalign)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        valid_d       = valid_q;
        mis_d         = mis_q;
        ferr_d        = ferr_q;
        cnt_d         = cnt_q;
        imem.imem_req = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    inst_d  = imem.imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StHold;
                end else if (cnt_q == TimeoutLast) begin
                    // Flag and keep retrying the same address.
                    ferr_d = 1'b1;
                    cnt_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (commit) begin
                    pc_d    = npc;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    mis_d   = mis_q | npc_misalign;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            ferr_q  <= ferr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign pc4            = pc_q + 32'd4;
    assign inst_valid     = valid_q;
    assign misalign_err   = mis_q;
    assign fetch_err      = ferr_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios followed by randomized fetch/commit
// traffic, checked against an arithmetic next-PC model and an expected-state tracker.
module tb_ifu_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] ra_data = 32'd0;
    logic        commit = 1'b0;
    logic [31:0] inst, pc, pc4;
    logic        inst_valid, misalign_err, fetch_err;

    ifu_fetch_if bus ();

    ifu_fetch #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .imem         (bus.master),
        .pcsource     (pcsource),
        .ra_data      (ra_data),
        .commit       (commit),
        .inst         (inst),
        .pc           (pc),
        .pc4          (pc4),
        .inst_valid   (inst_valid),
        .misalign_err (misalign_err),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_pc = 32'd0;
    logic        exp_mis = 1'b0;
    logic        exp_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next PC straight from the instruction-set rules, in plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] word,
                                              input logic [1:0] sel, input logic [31:0] ra);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        longint             off;
        seq = cur + 32'd4;
        case (sel)
            2'd0: return seq;
            2'd1: begin
                imm = word[15:0];
                off = longint'(imm);
                return seq + 32'(off * 4);
            end
            2'd2: return ra - (ra % 32'd4);
            default: return (seq & 32'hF000_0000) + (word % 32'h0400_0000) * 32'd4;
        endcase
    endfunction

    // One instruction: wait lat cycles, ack with word, hold, then commit with sel/ra.
    // noise adds a commit during REQ, acks during HOLD and an ack alongside commit.
    task automatic fetch(input int lat, input logic [31:0] word, input logic [1:0] sel,
                         input logic [31:0] ra, input int hold, input bit noise);
        chk("req", 32'(bus.imem_req), 32'd1);
        chk("addr", bus.imem_addr, exp_pc);
        for (int i = 0; i < lat; i++) begin
            commit = noise && (i == 0);
            step();
            commit = 1'b0;
            chk("wait_req", 32'(bus.imem_req), 32'd1);
            chk("wait_valid", 32'(inst_valid), 32'd0);
            chk("wait_addr", bus.imem_addr, exp_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, word);
        chk("pc", pc, exp_pc);
        chk("pc4", pc4, exp_pc + 32'd4);
        chk("req_hold", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.imem_ack = noise;
            step();
            bus.imem_ack = 1'b0;
            chk("hold_inst", inst, word);
            chk("hold_valid", 32'(inst_valid), 32'd1);
        end
        pcsource     = sel;
        ra_data      = ra;
        commit       = 1'b1;
        bus.imem_ack = noise;
        step();
        commit       = 1'b0;
        bus.imem_ack = 1'b0;
        pcsource     = 2'($urandom);
        ra_data      = $urandom;
        exp_pc = model_npc(exp_pc, word, sel, ra);
        if (sel == PCSRC_JR && (ra % 32'd4) != 32'd0) exp_mis = 1'b1;
        chk("npc_addr", bus.imem_addr, exp_pc);
        chk("npc_pc", pc, exp_pc);
        chk("valid_clr", 32'(inst_valid), 32'd0);
        chk("req_again", 32'(bus.imem_req), 32'd1);
        chk("misalign", 32'(misalign_err), 32'(exp_mis));
        chk("fetch_err", 32'(fetch_err), 32'(exp_ferr));
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        #3;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_errs", {30'd0, misalign_err, fetch_err}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        step();
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'd0);

        fetch(0, 32'h2001_0005, PCSRC_SEQ, 32'd0, 1, 1'b0);
        chk("seq_to_4", pc, 32'h4);
        fetch(3, {6'h02, 26'h000_0004}, PCSRC_J, 32'd0, 2, 1'b1);
        chk("j_to_10", pc, 32'h10);
        fetch(1, {6'h04, 5'd1, 5'd2, 16'hFFFF}, PCSRC_BR, 32'd0, 0, 1'b0);
        chk("beq_loop", pc, 32'h10);
        fetch(2, {6'h04, 5'd1, 5'd2, 16'h0003}, PCSRC_BR, 32'd0, 1, 1'b0);
        chk("beq_fwd", pc, 32'h20);
        fetch(0, {6'h00, 5'd31, 15'd0, 6'h08}, PCSRC_JR, 32'h103, 0, 1'b0);
        chk("jr_pc", pc, 32'h100);
        chk("jr_mis", 32'(misalign_err), 32'd1);
        fetch(0, {6'h02, 26'h000_0040}, PCSRC_J, 32'd0, 1, 1'b0);
        chk("j_to_100", pc, 32'h100);
        fetch(1, 32'h0000_0020, PCSRC_SEQ, 32'd0, 0, 1'b0);
        chk("mis_sticky", 32'(misalign_err), 32'd1);

        // Ack timeout at pc 0x104.
        for (int i = 0; i < 254; i++) step();
        chk("to_not_yet", 32'(fetch_err), 32'd0);
        step();
        exp_ferr = 1'b1;
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req", 32'(bus.imem_req), 32'd1);
        chk("to_addr", bus.imem_addr, 32'h104);
        fetch(0, {6'h02, 26'h000_0010}, PCSRC_J, 32'd0, 0, 1'b0);
        chk("j_to_40", pc, 32'h40);

        // Asynchronous reset mid-REQ.
        step();
        step();
        #3;
        clrn = 1'b0;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_errs", {30'd0, misalign_err, fetch_err}, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("arst_inst", inst, 32'd0);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", bus.imem_addr, 32'd0);
        chk("restart_valid", 32'(inst_valid), 32'd0);
        chk("restart_inst", inst, 32'd0);
        exp_pc   = 32'd0;
        exp_mis  = 1'b0;
        exp_ferr = 1'b0;

        for (int n = 0; n < 60; n++) begin
            fetch(int'($urandom_range(0, 5)), $urandom, 2'($urandom_range(0, 3)), $urandom,
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
